// File: rtl/axis_bram_adapter_cntl_if.sv
// ---------------------------------------------------------------------------
// axis_bram_adapter_cntl_if
//
// Bundles the stream handshake, BRAM control and lane-select signals that
// connect the adapter control FSM to the row-register datapath and BRAM.
//
// Handshake semantics:
//   stream_in_valid  : an input beat is present. The controller accepts it in
//                      any cycle it is in W_FILL, or in W_COMMIT when more rows
//                      follow. There is no ready back-pressure on the input.
//   stream_out_accep : the current output beat completes its handshake in this
//                      cycle. The lane selected by to_axis_mux_cntl is the
//                      beat offered, and stream_out_tlast marks the final one.
//
// Signals:
//   stream_in_valid     datapath -> cntl  input beat present
//   stream_out_accep    datapath -> cntl  output beat accepted this cycle
//   from_axis_mux_cntl  cntl -> datapath  2-bit code per lane (72 bits)
//   to_axis_mux_cntl    cntl -> datapath  lane driven onto the output stream
//   bram_wen            cntl -> BRAM      write enable
//   bram_en             cntl -> BRAM      enable
//   bram_index          cntl -> BRAM      row address
//   stream_out_tlast    cntl -> datapath  final output beat of the transfer
//
// Modports:
//   master : the control FSM
//   slave  : the datapath / BRAM side
// ---------------------------------------------------------------------------
interface axis_bram_adapter_cntl_if;
    logic        stream_in_valid;
    logic        stream_out_accep;
    logic [71:0] from_axis_mux_cntl;
    logic [5:0]  to_axis_mux_cntl;
    logic        bram_wen;
    logic        bram_en;
    logic [8:0]  bram_index;
    logic        stream_out_tlast;

    modport master (
        input  stream_in_valid,
        input  stream_out_accep,
        output from_axis_mux_cntl,
        output to_axis_mux_cntl,
        output bram_wen,
        output bram_en,
        output bram_index,
        output stream_out_tlast
    );

    modport slave (
        output stream_in_valid,
        output stream_out_accep,
        input  from_axis_mux_cntl,
        input  to_axis_mux_cntl,
        input  bram_wen,
        input  bram_en,
        input  bram_index,
        input  stream_out_tlast
    );
endinterface

// File: rtl/axis_bram_adapter_cntl.sv
// ---------------------------------------------------------------------------
// axis_bram_adapter_cntl
//
// Control FSM of the AXI-Stream <-> BRAM adapter. A row pointer walks the
// BRAM rows index_cntl..size_cntl (inclusive, modulo 512) and a beat counter
// tracks the stream beats within the current row.
//
//   rw = 1 : stream beats are packed into the external row register
//            (lane code 01) and the full row is written to BRAM.
//   rw = 0 : rows are fetched from BRAM into the row register (lane code 10)
//            and serialised onto the output stream, TLAST on the final beat.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   rw                 mode select (1 write, 0 read)
//   index_cntl         first BRAM row
//   size_cntl          last BRAM row, inclusive
//   bus                handshake / BRAM / lane-select interface (master side)
//   cnt                beat counter within the row (debug)
//   ptr_end            ptr == size_cntl (debug)
//   ptr_start          ptr == index_cntl (debug)
//   ptr_end_by_one     ptr == size_cntl - 1 mod 512 (debug)
//   fsm_state          current FSM state encoding (debug)
//
// All bus outputs are combinational decodes of state, ptr, cnt and inputs.
// ---------------------------------------------------------------------------
module axis_bram_adapter_cntl #(
    parameter int WORDS_PER_ROW = 36
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rw,
    input  logic [8:0] index_cntl,
    input  logic [8:0] size_cntl,
    axis_bram_adapter_cntl_if.master bus,
    output logic [5:0] cnt,
    output logic       ptr_end,
    output logic       ptr_start,
    output logic       ptr_end_by_one,
    output logic [2:0] fsm_state
);

    localparam logic [5:0] LAST_BEAT = 6'(WORDS_PER_ROW - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_FILL   = 3'd1,
        W_COMMIT = 3'd2,
        R_FETCH  = 3'd3,
        R_WAIT   = 3'd4,
        R_SEND   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t     state;
    logic [8:0] ptr;
    logic       mode;
    logic       abort;
    logic       commit_beat;

    // A change of rw away from the mode latched in IDLE abandons the transfer.
    assign abort = (state != IDLE) && (rw != mode);

    // In W_COMMIT the first beat of the next row lands in lane 0 while the
    // BRAM samples the completed row; on the final row nothing follows.
    assign commit_beat = (state == W_COMMIT) && bus.stream_in_valid &&
                         !ptr_end && !abort;

    assign ptr_start      = (ptr == index_cntl);
    assign ptr_end        = (ptr == size_cntl);
    assign ptr_end_by_one = (ptr == (size_cntl - 9'd1));
    assign fsm_state      = state;

    // -----------------------------------------------------------------------
    // State, pointer, counter and mode registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            ptr   <= 9'd0;
            cnt   <= 6'd0;
            mode  <= 1'b0;
        end else if (abort) begin
            // IDLE reloads ptr and cnt, so the partial row needs no cleanup.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    ptr   <= index_cntl;
                    cnt   <= 6'd0;
                    mode  <= rw;
                    state <= rw ? W_FILL : R_FETCH;
                end

                W_FILL: begin
                    if (bus.stream_in_valid) begin
                        if (cnt == LAST_BEAT) begin
                            cnt   <= 6'd0;
                            state <= W_COMMIT;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end

                W_COMMIT: begin
                    if (ptr_end) begin
                        state <= DONE;
                    end else begin
                        ptr   <= ptr + 9'd1;
                        cnt   <= commit_beat ? 6'd1 : 6'd0;
                        state <= W_FILL;
                    end
                end

                R_FETCH: begin
                    state <= R_WAIT;
                end

                R_WAIT: begin
                    cnt   <= 6'd0;
                    state <= R_SEND;
                end

                R_SEND: begin
                    if (bus.stream_out_accep) begin
                        if (cnt == LAST_BEAT) begin
                            cnt <= 6'd0;
                            if (ptr_end) begin
                                state <= DONE;
                            end else begin
                                ptr   <= ptr + 9'd1;
                                state <= R_FETCH;
                            end
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end

                DONE: begin
                    // Leaves only through the mode-change abort above.
                    state <= DONE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------------
    assign bus.bram_index = ptr;

    always_comb begin
        bus.from_axis_mux_cntl = '0;
        bus.to_axis_mux_cntl   = 6'd0;
        bus.bram_en            = 1'b0;
        bus.bram_wen           = 1'b0;
        bus.stream_out_tlast   = 1'b0;

        case (state)
            IDLE: begin
                // Clear code on every lane, including unused upper lanes.
                bus.from_axis_mux_cntl = '1;
            end

            W_FILL: begin
                if (bus.stream_in_valid) begin
                    for (int i = 0; i < WORDS_PER_ROW; i++) begin
                        if (6'(i) == cnt) begin
                            bus.from_axis_mux_cntl[2*i +: 2] = 2'b01;
                        end
                    end
                end
            end

            W_COMMIT: begin
                if (!abort) begin
                    bus.bram_en  = 1'b1;
                    bus.bram_wen = 1'b1;
                end
                if (commit_beat) begin
                    bus.from_axis_mux_cntl[1:0] = 2'b01;
                end
            end

            R_FETCH: begin
                bus.bram_en = 1'b1;
            end

            R_WAIT: begin
                // BRAM read data is valid now; load every used lane.
                for (int i = 0; i < WORDS_PER_ROW; i++) begin
                    bus.from_axis_mux_cntl[2*i +: 2] = 2'b10;
                end
            end

            R_SEND: begin
                bus.to_axis_mux_cntl = cnt;
                bus.stream_out_tlast = (cnt == LAST_BEAT) && ptr_end;
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axis_bram_adapter_cntl.sv
// ---------------------------------------------------------------------------
// tb_axis_bram_adapter_cntl
//
// Directed bench for the adapter control FSM (WORDS_PER_ROW = 36). Inputs
// change just after the falling edge; outputs are sampled 1 time unit later,
// well clear of the rising edge that updates the FSM.
// ---------------------------------------------------------------------------
module tb_axis_bram_adapter_cntl;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_FILL   = 3'd1;
    localparam logic [2:0] S_R_FETCH  = 3'd3;
    localparam logic [2:0] S_R_SEND   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;
    localparam logic [71:0] LANES_CLR = {72{1'b1}};
    localparam logic [71:0] LANES_RD  = {36{2'b10}};

    logic       clk = 1'b0;
    logic       rstn;
    logic       rw;
    logic [8:0] index_cntl;
    logic [8:0] size_cntl;
    logic [5:0] cnt;
    logic       ptr_end;
    logic       ptr_start;
    logic       ptr_end_by_one;
    logic [2:0] fsm_state;

    logic [8:0] exp_q[$];
    int         vec_cnt = 0;
    int         err_cnt = 0;

    axis_bram_adapter_cntl_if bus();

    axis_bram_adapter_cntl #(.WORDS_PER_ROW(36)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rw             (rw),
        .index_cntl     (index_cntl),
        .size_cntl      (size_cntl),
        .bus            (bus),
        .cnt            (cnt),
        .ptr_end        (ptr_end),
        .ptr_start      (ptr_start),
        .ptr_end_by_one (ptr_end_by_one),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Ends on a falling edge with rstn released and the FSM in IDLE.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk); #1;
        vec_cnt++;
        if (bus.from_axis_mux_cntl !== LANES_CLR) begin
            err_cnt++;
            $display("FAIL reset_lanes got=%h exp=%h", bus.from_axis_mux_cntl, LANES_CLR);
        end
        vec_cnt++;
        if ({bus.bram_en, bus.bram_wen, bus.bram_index, bus.stream_out_tlast,
             bus.to_axis_mux_cntl, cnt, fsm_state} !== 27'd0) begin
            err_cnt++;
            $display("FAIL reset_outs en=%b wen=%b idx=%0d tlast=%b to=%0d cnt=%0d st=%0d exp all 0",
                     bus.bram_en, bus.bram_wen, bus.bram_index, bus.stream_out_tlast,
                     bus.to_axis_mux_cntl, cnt, fsm_state);
        end
    endtask

    task automatic test_write_full();
        logic [8:0] exp_a;
        rw = 1'b1; index_cntl = 9'd0; size_cntl = 9'd15;
        bus.stream_in_valid = 1'b0; bus.stream_out_accep = 1'b0;
        do_reset();
        bus.stream_in_valid = 1'b1;
        for (int r = 0; r < 16; r++) exp_q.push_back(9'(r));
        for (int r = 0; r < 16; r++) begin
            for (int k = (r == 0) ? 0 : 1; k < 36; k++) begin
                @(negedge clk); #1;
                vec_cnt++;
                if ({bus.bram_en, bus.from_axis_mux_cntl} !== {1'b0, 72'h1 << (2*k)}) begin
                    err_cnt++;
                    $display("FAIL wr_fill r=%0d k=%0d got en=%b lanes=%h exp en=0 lanes=%h",
                             r, k, bus.bram_en, bus.from_axis_mux_cntl, 72'h1 << (2*k));
                end
            end
            @(negedge clk); #1;
            exp_a = exp_q.pop_front();
            vec_cnt++;
            if ({bus.bram_en, bus.bram_wen, bus.bram_index} !== {2'b11, exp_a}) begin
                err_cnt++;
                $display("FAIL wr_commit r=%0d got en=%b wen=%b idx=%0d exp en=1 wen=1 idx=%0d",
                         r, bus.bram_en, bus.bram_wen, bus.bram_index, exp_a);
            end
            vec_cnt++;
            if (bus.from_axis_mux_cntl !== ((r < 15) ? 72'h1 : 72'h0)) begin
                err_cnt++;
                $display("FAIL wr_commit_lane r=%0d got=%h exp=%h",
                         r, bus.from_axis_mux_cntl, (r < 15) ? 72'h1 : 72'h0);
            end
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_en, bus.from_axis_mux_cntl} !== {S_DONE, 1'b0, 72'h0}) begin
            err_cnt++;
            $display("FAIL wr_done got st=%0d en=%b lanes=%h exp st=%0d en=0 lanes=0",
                     fsm_state, bus.bram_en, bus.from_axis_mux_cntl, S_DONE);
        end
    endtask

    task automatic test_reset_mid();
        rw = 1'b1; index_cntl = 9'd0; size_cntl = 9'd0;
        do_reset();
        bus.stream_in_valid = 1'b1;
        repeat (6) begin @(negedge clk); #1; end
        vec_cnt++;
        if (cnt !== 6'd5) begin
            err_cnt++;
            $display("FAIL rmid_cnt got=%0d exp=5", cnt);
        end
        rstn = 1'b0; #1;
        vec_cnt++;
        if (bus.from_axis_mux_cntl !== LANES_CLR) begin
            err_cnt++;
            $display("FAIL rmid_lanes got=%h exp=%h", bus.from_axis_mux_cntl, LANES_CLR);
        end
        vec_cnt++;
        if ({bus.bram_en, bus.bram_wen, bus.bram_index, bus.stream_out_tlast,
             bus.to_axis_mux_cntl, cnt, fsm_state} !== 27'd0) begin
            err_cnt++;
            $display("FAIL rmid_outs en=%b wen=%b idx=%0d tlast=%b to=%0d cnt=%0d st=%0d exp all 0",
                     bus.bram_en, bus.bram_wen, bus.bram_index, bus.stream_out_tlast,
                     bus.to_axis_mux_cntl, cnt, fsm_state);
        end
        index_cntl = 9'd3; size_cntl = 9'd3;
        @(negedge clk); rstn = 1'b1; #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_index} !== {S_IDLE, 9'd0}) begin
            err_cnt++;
            $display("FAIL rmid_idle got st=%0d idx=%0d exp st=0 idx=0", fsm_state, bus.bram_index);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_index, ptr_start, ptr_end} !== {S_W_FILL, 9'd3, 2'b11}) begin
            err_cnt++;
            $display("FAIL rmid_restart got st=%0d idx=%0d ps=%b pe=%b exp st=1 idx=3 ps=1 pe=1",
                     fsm_state, bus.bram_index, ptr_start, ptr_end);
        end
    endtask

    task automatic test_write_gap();
        rw = 1'b1; index_cntl = 9'd0; size_cntl = 9'd0;
        bus.stream_in_valid = 1'b0;
        do_reset();
        bus.stream_in_valid = 1'b1;
        repeat (10) begin @(negedge clk); #1; end
        for (int g = 0; g < 3; g++) begin
            @(negedge clk); bus.stream_in_valid = 1'b0; #1;
            vec_cnt++;
            if ({cnt, bus.from_axis_mux_cntl, bus.bram_en} !== {6'd10, 72'h0, 1'b0}) begin
                err_cnt++;
                $display("FAIL gap_hold g=%0d got cnt=%0d lanes=%h en=%b exp cnt=10 lanes=0 en=0",
                         g, cnt, bus.from_axis_mux_cntl, bus.bram_en);
            end
        end
        @(negedge clk); bus.stream_in_valid = 1'b1; #1;
        vec_cnt++;
        if ({cnt, bus.from_axis_mux_cntl} !== {6'd10, 72'h1 << 20}) begin
            err_cnt++;
            $display("FAIL gap_resume got cnt=%0d lanes=%h exp cnt=10 lanes=%h",
                     cnt, bus.from_axis_mux_cntl, 72'h1 << 20);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if (cnt !== 6'd11) begin
            err_cnt++;
            $display("FAIL gap_advance got=%0d exp=11", cnt);
        end
    endtask

    task automatic test_mode_abort();
        rw = 1'b1; index_cntl = 9'd0; size_cntl = 9'd0;
        do_reset();
        bus.stream_in_valid = 1'b1;
        repeat (5) begin @(negedge clk); #1; end
        @(negedge clk); rw = 1'b0; #1;
        vec_cnt++;
        if (bus.bram_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_noen got=%b exp=0", bus.bram_en);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_en, bus.bram_wen} !== {S_IDLE, 2'b00}) begin
            err_cnt++;
            $display("FAIL abort_idle got st=%0d en=%b wen=%b exp st=0 en=0 wen=0",
                     fsm_state, bus.bram_en, bus.bram_wen);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_en, bus.bram_wen, bus.bram_index} !== {S_R_FETCH, 2'b10, 9'd0}) begin
            err_cnt++;
            $display("FAIL abort_read got st=%0d en=%b wen=%b idx=%0d exp st=3 en=1 wen=0 idx=0",
                     fsm_state, bus.bram_en, bus.bram_wen, bus.bram_index);
        end
        bus.stream_in_valid = 1'b0;
    endtask

    task automatic test_read();
        logic [8:0] exp_a;
        rw = 1'b0; index_cntl = 9'd4; size_cntl = 9'd5;
        bus.stream_in_valid = 1'b0; bus.stream_out_accep = 1'b1;
        exp_q.push_back(9'd4); exp_q.push_back(9'd5);
        do_reset();
        for (int r = 4; r <= 5; r++) begin
            @(negedge clk); #1;
            exp_a = exp_q.pop_front();
            vec_cnt++;
            if ({bus.bram_en, bus.bram_wen, bus.bram_index} !== {2'b10, exp_a}) begin
                err_cnt++;
                $display("FAIL rd_fetch r=%0d got en=%b wen=%b idx=%0d exp en=1 wen=0 idx=%0d",
                         r, bus.bram_en, bus.bram_wen, bus.bram_index, exp_a);
            end
            @(negedge clk); #1;
            vec_cnt++;
            if ({bus.from_axis_mux_cntl, bus.bram_en} !== {LANES_RD, 1'b0}) begin
                err_cnt++;
                $display("FAIL rd_wait r=%0d got lanes=%h en=%b exp lanes=%h en=0",
                         r, bus.from_axis_mux_cntl, bus.bram_en, LANES_RD);
            end
            for (int k = 0; k < 36; k++) begin
                @(negedge clk); #1;
                vec_cnt++;
                if ({bus.to_axis_mux_cntl, bus.stream_out_tlast} !== {6'(k), (r == 5 && k == 35)}) begin
                    err_cnt++;
                    $display("FAIL rd_send r=%0d k=%0d got to=%0d tlast=%b exp to=%0d tlast=%b",
                             r, k, bus.to_axis_mux_cntl, bus.stream_out_tlast, k, (r == 5 && k == 35));
                end
            end
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.stream_out_tlast, bus.bram_en} !== {S_DONE, 2'b00}) begin
            err_cnt++;
            $display("FAIL rd_done got st=%0d tlast=%b en=%b exp st=6 tlast=0 en=0",
                     fsm_state, bus.stream_out_tlast, bus.bram_en);
        end
    endtask

    task automatic test_backpressure();
        rw = 1'b0; index_cntl = 9'd9; size_cntl = 9'd9;
        bus.stream_out_accep = 1'b1;
        do_reset();
        @(negedge clk); #1;
        @(negedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
        end
        for (int s = 0; s < 4; s++) begin
            @(negedge clk); bus.stream_out_accep = 1'b0; #1;
            vec_cnt++;
            if ({bus.to_axis_mux_cntl, cnt, bus.stream_out_tlast} !== {6'd20, 6'd20, 1'b0}) begin
                err_cnt++;
                $display("FAIL bp_hold s=%0d got to=%0d cnt=%0d tlast=%b exp to=20 cnt=20 tlast=0",
                         s, bus.to_axis_mux_cntl, cnt, bus.stream_out_tlast);
            end
        end
        for (int k = 20; k < 36; k++) begin
            @(negedge clk); bus.stream_out_accep = 1'b1; #1;
            vec_cnt++;
            if ({fsm_state, bus.to_axis_mux_cntl, bus.stream_out_tlast} !== {S_R_SEND, 6'(k), (k == 35)}) begin
                err_cnt++;
                $display("FAIL bp_resume k=%0d got st=%0d to=%0d tlast=%b exp st=5 to=%0d tlast=%b",
                         k, fsm_state, bus.to_axis_mux_cntl, bus.stream_out_tlast, k, (k == 35));
            end
        end
        @(negedge clk); #1;
        vec_cnt++;
        if (fsm_state !== S_DONE) begin
            err_cnt++;
            $display("FAIL bp_done got st=%0d exp=6", fsm_state);
        end
    endtask

    // Read walk checking fetch addresses and the three pointer flags per row.
    task automatic test_flags(input logic [8:0] idx, input logic [8:0] sz, input int nrows);
        logic [8:0] exp_a;
        rw = 1'b0; index_cntl = idx; size_cntl = sz;
        bus.stream_out_accep = 1'b1;
        for (int i = 0; i < nrows; i++) exp_q.push_back(idx + 9'(i));
        do_reset();
        for (int i = 0; i < nrows; i++) begin
            @(negedge clk); #1;
            exp_a = exp_q.pop_front();
            vec_cnt++;
            if ({bus.bram_en, bus.bram_index, ptr_start, ptr_end_by_one, ptr_end} !==
                {1'b1, exp_a, (i == 0), (i == nrows - 2), (i == nrows - 1)}) begin
                err_cnt++;
                $display("FAIL flags i=%0d got en=%b idx=%0d ps=%b peb1=%b pe=%b exp en=1 idx=%0d ps=%b peb1=%b pe=%b",
                         i, bus.bram_en, bus.bram_index, ptr_start, ptr_end_by_one, ptr_end,
                         exp_a, (i == 0), (i == nrows - 2), (i == nrows - 1));
            end
            repeat (37) begin @(negedge clk); #1; end
        end
        @(negedge clk); #1;
        vec_cnt++;
        if (fsm_state !== S_DONE) begin
            err_cnt++;
            $display("FAIL flags_done idx=%0d got st=%0d exp=6", idx, fsm_state);
        end
    endtask

    task automatic test_done_toggle();
        bus.stream_in_valid = 1'b0;
        @(negedge clk); rw = 1'b1; #1;
        vec_cnt++;
        if (fsm_state !== S_DONE) begin
            err_cnt++;
            $display("FAIL tog_done got st=%0d exp=6", fsm_state);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.from_axis_mux_cntl} !== {S_IDLE, LANES_CLR}) begin
            err_cnt++;
            $display("FAIL tog_idle got st=%0d lanes=%h exp st=0 lanes=all ones",
                     fsm_state, bus.from_axis_mux_cntl);
        end
        @(negedge clk); #1;
        vec_cnt++;
        if ({fsm_state, bus.bram_index, cnt} !== {S_W_FILL, 9'd2, 6'd0}) begin
            err_cnt++;
            $display("FAIL tog_write got st=%0d idx=%0d cnt=%0d exp st=1 idx=2 cnt=0",
                     fsm_state, bus.bram_index, cnt);
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rstn = 1'b0; rw = 1'b0; index_cntl = 9'd0; size_cntl = 9'd0;
        bus.stream_in_valid = 1'b0; bus.stream_out_accep = 1'b0;
        test_reset();
        test_write_full();
        test_reset_mid();
        test_write_gap();
        test_mode_abort();
        test_read();
        test_backpressure();
        test_flags(9'd510, 9'd1, 4);
        test_flags(9'd2, 9'd7, 6);
        test_done_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/axis_bram_adapter_cntl.md
Name: axis_bram_adapter_cntl

Overview:
- Control FSM of the AXI-Stream <-> BRAM adapter.
- Sequences a row pointer over BRAM rows index_cntl..size_cntl (inclusive) and counts stream beats within a row.
- Drives BRAM enable/write-enable/address and the lane-select codes for the external row-register datapath.
- Write mode (rw=1) packs incoming stream beats into rows and writes them to BRAM. Read mode (rw=0) fetches rows and serialises them onto the output stream with TLAST on the final beat.

Parameters:
WORDS_PER_ROW, 36, stream beats per BRAM row; legal range 2..36, limited by the 72-bit lane bus and 6-bit cnt.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rstn  in  1  asynchronous, active-low reset.
rw  in  1  mode select: 1 = stream->BRAM write, 0 = BRAM->stream read.
index_cntl  in  9  first BRAM row address.
size_cntl  in  9  last BRAM row address, inclusive.
stream_in_valid  in  1  input beat present; always accepted in W_FILL/W_COMMIT.
stream_out_accep  in  1  output beat handshake completes this cycle.
from_axis_mux_cntl  out  72  per-lane 2-bit code, lane i = bits [2i+1:2i]: 00 hold, 01 load stream beat, 10 load BRAM row, 11 clear.
to_axis_mux_cntl  out  6  lane driven onto the output stream (= cnt in R_SEND, else 0).
bram_wen  out  1  BRAM write enable.
bram_en  out  1  BRAM enable.
bram_index  out  9  BRAM row address; always equals ptr.
stream_out_tlast  out  1  last output beat of the transfer.
cnt  out  6  beat counter within the current row (debug).
ptr_end  out  1  ptr == size_cntl (debug).
ptr_start  out  1  ptr == index_cntl (debug).
ptr_end_by_one  out  1  ptr == size_cntl-1 mod 512 (debug).

Behaviour:
- Reset (rstn=0, asynchronous): state IDLE, ptr=0, cnt=0, latched mode=0.
- Reset output values: every output is 0 except from_axis_mux_cntl, which is all 1s (IDLE clear code). ptr_start/ptr_end/ptr_end_by_one follow their comparisons combinationally.
- All outputs are combinational decodes of state, ptr, cnt and inputs.
- IDLE:
  - Lanes=11, ptr<=index_cntl, cnt<=0, mode<=rw.
  - Next state W_FILL if rw=1, else R_FETCH.
- W_FILL:
  - When stream_in_valid=1: lane[cnt]=01, cnt++.
  - When the beat at cnt==WORDS_PER_ROW-1 is accepted: cnt<=0, next W_COMMIT.
- W_COMMIT:
  - bram_en=1, bram_wen=1, bram_index=ptr (one-cycle write pulse).
  - A beat is accepted concurrently into lane 0 (lane0=01, cnt<=1) unless ptr_end=1. The BRAM samples the old row value.
  - If ptr_end: next DONE. Else ptr++ and next W_FILL.
- R_FETCH: bram_en=1, bram_wen=0; next R_WAIT.
- R_WAIT: fixed 1-cycle BRAM read latency; all lanes=10; cnt<=0; next R_SEND.
- R_SEND:
  - to_axis_mux_cntl=cnt.
  - On stream_out_accep: cnt++.
  - On an accepted beat with cnt==WORDS_PER_ROW-1: if ptr_end, next DONE; else ptr++, cnt<=0, next R_FETCH.
  - stream_out_tlast = (state==R_SEND && cnt==WORDS_PER_ROW-1 && ptr_end); the flag is independent of stream_out_accep.
- DONE: all lanes=00, no BRAM access. Stays in DONE until rw != latched mode, then next IDLE.
- Mode abort: rw != latched mode in any non-IDLE state -> next IDLE; any partial row is discarded and no BRAM write occurs.
- ptr increments modulo 512. If size_cntl < index_cntl, ptr wraps through 511->0 until it equals size_cntl.
- index_cntl and size_cntl must be held stable outside IDLE; they are compared live.
- Lane codes for lanes >= WORDS_PER_ROW are always 00, except the all-11 clear code in IDLE.

Test Plan:
- Reset mid-transfer (rstn low while in W_FILL with cnt=5): all outputs zero and lanes all 1s immediately. After release, restarts from IDLE with ptr=index_cntl.
- Write, index=0, size=15, rw=1, valid held 1 from the 3rd cycle after reset: 576 beats accepted with no stall. Exactly 16 bram_en&bram_wen pulses at addresses 0..15. Each pulse follows the 36th beat of its row. Ends in DONE.
- Write with gapped valid (valid low for 3 cycles at cnt=10): cnt holds at 10, lanes 00, no BRAM activity. Resumes at lane 10 when valid returns.
- Read, index=4, size=5, rw=0, accep held 1: en pulse at address 4; lanes all 10 one cycle later; to_axis_mux_cntl steps 0..35. Same sequence repeats for address 5. tlast is high only on beat 35 of row 5.
- Read backpressure (accep low for 4 cycles at cnt=20): to_axis_mux_cntl holds 20, no count advance, tlast stays low.
- Debug flags with index=2, size=7: ptr_start high only at ptr=2, ptr_end_by_one only at 6, ptr_end only at 7. Toggling rw in DONE returns the FSM to IDLE, which starts the opposite mode.
